// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse train generator.
// Combinational definitions only; no state, no backpressure.
package pulse_gen_pkg;

  localparam int LEN_W_DEF = 8;
  localparam int NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // A zero-length phase would have no cycle to live in, so it runs as one cycle.
  function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter with a terminal-count flag; load wins over decrement.
// One-cycle registered update; the counter holds at zero, so it never wraps.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst generator: P pulses of H cycles high then L cycles low, plus edge strobes and done.
// All outputs registered, one cycle after the deciding edge; start accepted only when idle.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [LEN_W-1:0] high_len_i,
  input  logic [LEN_W-1:0] low_len_i,
  input  logic [NUM_W-1:0] pulse_cnt_i,
  output logic             sig_out_o,
  output logic             rise_strb_o,
  output logic             fall_strb_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] h_len_q, h_len_d;
  logic [LEN_W-1:0] l_len_q, l_len_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             sig_q, sig_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic [LEN_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_tc;

  logic [LEN_W-1:0] h_clamp;
  logic [LEN_W-1:0] l_clamp;

  assign h_clamp = LEN_W'(clamp_to_one(32'(high_len_i)));
  assign l_clamp = LEN_W'(clamp_to_one(32'(low_len_i)));

  phase_counter #(
    .W(LEN_W)
  ) u_phase_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .tc_o      (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    h_len_d      = h_len_q;
    l_len_d      = l_len_q;
    rem_d        = rem_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          h_len_d = h_clamp;
          l_len_d = l_clamp;
          if (pulse_cnt_i != '0) begin
            state_d      = HIGH;
            rem_d        = pulse_cnt_i;
            rise_d       = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = h_clamp - LEN_W'(1);
          end else begin
            done_d = 1'b1;
          end
        end
      end

      HIGH: begin
        if (stop_i) begin
          state_d = IDLE;
          fall_d  = sig_q;
        end else if (cnt_tc) begin
          state_d      = LOW;
          fall_d       = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = l_len_q - LEN_W'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end

      LOW: begin
        if (stop_i) begin
          state_d = IDLE;
          fall_d  = sig_q;
        end else if (cnt_tc) begin
          // rem_q still counts the pulse whose LOW phase is ending now.
          if (rem_q > NUM_W'(1)) begin
            state_d      = HIGH;
            rem_d        = rem_q - NUM_W'(1);
            rise_d       = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = h_len_q - LEN_W'(1);
          end else begin
            state_d = IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    sig_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      h_len_q <= '0;
      l_len_q <= '0;
      rem_q   <= '0;
      sig_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_len_q <= h_len_d;
      l_len_q <= l_len_d;
      rem_q   <= rem_d;
      sig_q   <= sig_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sig_out_o   = sig_q;
  assign rise_strb_o = rise_q;
  assign fall_strb_o = fall_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
